// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: 32-cycle shift-add multiply / restoring divide,
// followed by one sign-fix cycle, plus direct MTHI/MTLO writes while idle.
module mult_div_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] srcA,
   input  logic [31:0] srcB,
   input  logic        writeHi,
   input  logic        writeLo,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {IDLE, CALC, FIX} stateT;

   stateT       state, nextState;
   logic        divOp;
   logic        negQuot;
   logic        negRem;
   logic        divZero;
   logic [31:0] absA;
   logic [31:0] absB;
   logic [31:0] rawA;
   logic [31:0] shiftReg;
   logic [63:0] acc;
   logic [5:0]  count;

   logic        signedOp;
   logic        signA;
   logic        signB;
   logic [32:0] mulSum;
   logic [32:0] trial;
   logic [32:0] trialDiff;
   logic        qBit;
   logic [31:0] remNext;
   logic [63:0] prodFixed;
   logic [31:0] quotFixed;
   logic [31:0] remFixed;

   assign busy = (state != IDLE);

   // State register for the IDLE -> CALC -> FIX sequence
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= nextState;
   end

   // Next-state logic: CALC runs exactly 32 iterations before the fix-up cycle
   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (start) nextState = CALC;
         CALC:    if (count == 6'd31) nextState = FIX;
         FIX:     nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Operand conditioning at capture, one iteration step, and final sign correction
   always_comb begin
      signedOp  = ~op[0];
      signA     = signedOp & srcA[31];
      signB     = signedOp & srcB[31];
      mulSum    = {1'b0, acc[63:32]} + (shiftReg[0] ? {1'b0, absA} : 33'd0);
      trial     = {acc[63:32], shiftReg[31]};
      trialDiff = trial - {1'b0, absB};
      qBit      = ~trialDiff[32];
      remNext   = qBit ? trialDiff[31:0] : trial[31:0];
      prodFixed = negQuot ? (64'd0 - acc) : acc;
      quotFixed = negQuot ? (32'd0 - acc[31:0]) : acc[31:0];
      remFixed  = negRem ? (32'd0 - acc[63:32]) : acc[63:32];
   end

   // Datapath: capture at start, iterate in CALC, commit hi/lo in FIX or on MTHI/MTLO
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         divOp    <= 1'b0;
         negQuot  <= 1'b0;
         negRem   <= 1'b0;
         divZero  <= 1'b0;
         absA     <= 32'd0;
         absB     <= 32'd0;
         rawA     <= 32'd0;
         shiftReg <= 32'd0;
         acc      <= 64'd0;
         count    <= 6'd0;
         hi       <= 32'd0;
         lo       <= 32'd0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  divOp    <= op[1];
                  negQuot  <= signA ^ signB;
                  negRem   <= op[1] & signA;
                  divZero  <= (srcB == 32'd0);
                  absA     <= signA ? (32'd0 - srcA) : srcA;
                  absB     <= signB ? (32'd0 - srcB) : srcB;
                  rawA     <= srcA;
                  shiftReg <= op[1] ? (signA ? (32'd0 - srcA) : srcA)
                                    : (signB ? (32'd0 - srcB) : srcB);
                  acc      <= 64'd0;
                  count    <= 6'd0;
               end else begin
                  if (writeHi) hi <= srcA;
                  if (writeLo) lo <= srcA;
               end
            end
            CALC: begin
               count <= count + 6'd1;
               if (divOp) begin
                  acc      <= {remNext, acc[30:0], qBit};
                  shiftReg <= {shiftReg[30:0], 1'b0};
               end else begin
                  acc      <= {mulSum, acc[31:1]};
                  shiftReg <= {1'b0, shiftReg[31:1]};
               end
            end
            FIX: begin
               done <= 1'b1;
               if (divOp && divZero) begin
                  hi <= rawA;
                  lo <= 32'hFFFFFFFF;
               end else if (divOp) begin
                  hi <= remFixed;
                  lo <= quotFixed;
               end else begin
                  hi <= prodFixed[63:32];
                  lo <= prodFixed[31:0];
               end
            end
            default: ;
         endcase
      end
   end

endmodule
